// File: rtl/pcpu_pkg.sv
// Shared definitions for the parametrised multi-cycle CPU: opcodes, FSM states
// and the bit positions of the {C,V,N,Z} status flags.
package pcpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BN   = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    HALT
  } state_t;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Register-writing ALU ops occupy a contiguous opcode range.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  function automatic logic sets_flags(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/pcpu_alu.sv
// Combinational ALU: one result plus the C, V, N, Z flags for the ALU-class
// opcodes; SHL/SHR shift operand a by one and ignore b.
module pcpu_alu
  import pcpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              v,
  output logic              n,
  output logic              z
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] sum;

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned; otherwise synthesis infers a latch to hold it.
  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[MSB:0];
        c      = sum[DATA_W];
        v      = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        // Subtract as a + ~b + 1, so carry out set means no borrow.
        sum    = {1'b0, a} + {1'b0, ~b} + (DATA_W + 1)'(1);
        result = sum[MSB:0];
        c      = sum[DATA_W];
        v      = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[MSB-1:0], 1'b0};
        c      = a[MSB];
      end
      OP_SHR: begin
        result = {1'b0, a[MSB:1]};
        c      = a[0];
      end
      default: ;
    endcase
    n = result[MSB];
    z = (result == '0);
  end

endmodule

// File: rtl/param_mcpu.sv
// Parametrised multi-cycle CPU: FETCH/DECODE/EXEC or MEM, with request/ack
// handshakes on separate instruction and data ports and a terminal HALT state.
module param_mcpu
  import pcpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] alu_result,
  output logic [3:0]        stat,
  output logic              halted
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   alu_result_q, alu_result_d;
  logic [3:0]          stat_q, stat_d;

  logic [3:0]          op;
  logic [1:0]          rd;
  logic [1:0]          rs;
  logic [7:0]          imm;
  logic [ADDR_W-1:0]   imm_addr;
  logic [DATA_W-1:0]   imm_data;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_v, alu_n, alu_z;

  assign op       = ir_q[15:12];
  assign rd       = ir_q[11:10];
  assign rs       = ir_q[9:8];
  assign imm      = ir_q[7:0];
  assign imm_addr = imm[ADDR_W-1:0];
  assign imm_data = DATA_W'(imm);

  pcpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op),
    .a      (opa_q),
    .b      (opb_q),
    .result (alu_res),
    .c      (alu_c),
    .v      (alu_v),
    .n      (alu_n),
    .z      (alu_z)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    regs_d       = regs_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    alu_result_d = alu_result_q;
    stat_d       = stat_q;

    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = DECODE;
        end
      end

      DECODE: begin
        opa_d = regs_q[rd];
        opb_d = regs_q[rs];
        case (op)
          OP_LD, OP_ST: state_d = MEM;
          OP_HALT:      state_d = HALT;
          default:      state_d = EXEC;
        endcase
      end

      EXEC: begin
        state_d = FETCH;
        if (sets_flags(op)) begin
          stat_d[FLAG_C] = alu_c;
          stat_d[FLAG_V] = alu_v;
          stat_d[FLAG_N] = alu_n;
          stat_d[FLAG_Z] = alu_z;
          alu_result_d   = alu_res;
        end
        if (is_alu_op(op)) regs_d[rd] = alu_res;
        // Branches test the flags held in stat_q, i.e. before this cycle's update.
        case (op)
          OP_LDI: regs_d[rd] = imm_data;
          OP_JMP: pc_d = imm_addr;
          OP_BZ:  if (stat_q[FLAG_Z]) pc_d = imm_addr;
          OP_BN:  if (stat_q[FLAG_N]) pc_d = imm_addr;
          default: ;
        endcase
      end

      MEM: begin
        if (dmem_ack) begin
          if (op == OP_LD) regs_d[rd] = dmem_rdata;
          state_d = FETCH;
        end
      end

      HALT: state_d = HALT;

      default: state_d = FETCH;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  // NOTE: the register file is small and architecturally required to clear on
  // reset, so it is reset here like any other flop rather than left as RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      alu_result_q <= '0;
      stat_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      regs_q       <= regs_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      alu_result_q <= alu_result_d;
      stat_q       <= stat_d;
    end
  end

  // The fetch request is gated by rst so it drops the moment reset asserts.
  assign imem_req   = (state_q == FETCH) && !rst;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == MEM);
  assign dmem_we    = (state_q == MEM) && (op == OP_ST);
  assign dmem_addr  = imm_addr;
  assign dmem_wdata = opa_q;
  assign alu_result = alu_result_q;
  assign stat       = stat_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_param_mcpu.sv
// Directed bench for param_mcpu: an 8-bit core checked with an ALU vector table
// and hand-written timing/branch/memory/reset sequences, plus a 16-bit core.
module tb_param_mcpu;
  import pcpu_pkg::*;

  logic clk;
  logic rst;

  logic        imem_req8, imem_ack8;
  logic [7:0]  imem_addr8;
  logic [15:0] imem_data8;
  logic        dmem_req8, dmem_we8, dmem_ack8;
  logic [7:0]  dmem_addr8, dmem_wdata8, dmem_rdata8;
  logic [7:0]  alu8;
  logic [3:0]  stat8;
  logic        halted8;

  logic        imem_req16, imem_ack16;
  logic [7:0]  imem_addr16;
  logic [15:0] imem_data16;
  logic        dmem_req16, dmem_we16, dmem_ack16;
  logic [7:0]  dmem_addr16;
  logic [15:0] dmem_wdata16, dmem_rdata16;
  logic [15:0] alu16;
  logic [3:0]  stat16;
  logic        halted16;

  logic [15:0] imem8  [256];
  logic [15:0] imem16 [256];
  int          dmem_wait;
  int          wait_cnt;
  logic [7:0]  st_addr, st_data;
  int          overlap_cnt;

  int n_checks;
  int n_fail;

  param_mcpu #(.DATA_W(8), .ADDR_W(8), .NREG(4)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req8),
    .imem_addr  (imem_addr8),
    .imem_ack   (imem_ack8),
    .imem_data  (imem_data8),
    .dmem_req   (dmem_req8),
    .dmem_we    (dmem_we8),
    .dmem_addr  (dmem_addr8),
    .dmem_wdata (dmem_wdata8),
    .dmem_ack   (dmem_ack8),
    .dmem_rdata (dmem_rdata8),
    .alu_result (alu8),
    .stat       (stat8),
    .halted     (halted8)
  );

  param_mcpu #(.DATA_W(16), .ADDR_W(8), .NREG(4)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req16),
    .imem_addr  (imem_addr16),
    .imem_ack   (imem_ack16),
    .imem_data  (imem_data16),
    .dmem_req   (dmem_req16),
    .dmem_we    (dmem_we16),
    .dmem_addr  (dmem_addr16),
    .dmem_wdata (dmem_wdata16),
    .dmem_ack   (dmem_ack16),
    .dmem_rdata (dmem_rdata16),
    .alu_result (alu16),
    .stat       (stat16),
    .halted     (halted16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responders: zero-wait instruction memory, data memory with a
  // programmable number of wait cycles, load data = 0xA5 ^ address.
  assign imem_ack8    = imem_req8;
  assign imem_data8   = imem8[imem_addr8];
  assign dmem_ack8    = dmem_req8 && (wait_cnt == dmem_wait);
  assign dmem_rdata8  = 8'hA5 ^ dmem_addr8;

  assign imem_ack16   = imem_req16;
  assign imem_data16  = imem16[imem_addr16];
  assign dmem_ack16   = dmem_req16;
  assign dmem_rdata16 = {dmem_addr16, 8'h01};

  always @(posedge clk) begin
    wait_cnt <= (dmem_req8 && !dmem_ack8) ? wait_cnt + 1 : 0;
    if (dmem_req8 && dmem_ack8 && dmem_we8) begin
      st_addr <= dmem_addr8;
      st_data <= dmem_wdata8;
    end
  end

  always @(negedge clk) begin
    if (imem_req8 && dmem_req8) overlap_cnt++;
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    bit         chk_res;
    logic [7:0] exp_res;
    logic [3:0] exp_stat;
    logic [7:0] exp_mem;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem8[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_halt8(input string name);
    int n = 0;
    while (!halted8 && n < 200) begin
      edges(1);
      n++;
    end
    check({name, " halted"}, 32'(halted8), 32'd1);
  endtask

  initial begin
    int req_cnt;
    int bad;
    int n;

    n_checks    = 0;
    n_fail      = 0;
    overlap_cnt = 0;
    dmem_wait   = 0;
    rst         = 1'b1;

    vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0110, 8'h80};
    vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b1001, 8'h00};
    vecs[2]  = '{OP_SUB, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1001, 8'h00};
    vecs[3]  = '{OP_SUB, 8'h03, 8'h05, 1'b1, 8'hFE, 4'b0010, 8'hFE};
    vecs[4]  = '{OP_SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b1100, 8'h7F};
    vecs[5]  = '{OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000, 8'h30};
    vecs[6]  = '{OP_OR,  8'hF0, 8'h0F, 1'b1, 8'hFF, 4'b0010, 8'hFF};
    vecs[7]  = '{OP_XOR, 8'hAA, 8'hAA, 1'b1, 8'h00, 4'b0001, 8'h00};
    vecs[8]  = '{OP_SHL, 8'h81, 8'h01, 1'b1, 8'h02, 4'b1000, 8'h02};
    vecs[9]  = '{OP_SHR, 8'h81, 8'h01, 1'b1, 8'h40, 4'b1000, 8'h40};
    vecs[10] = '{OP_CMP, 8'h05, 8'h07, 1'b0, 8'hFE, 4'b0010, 8'h05};

    for (int i = 0; i < 256; i++) imem16[i] = 16'h0000;
    imem16[0] = 16'h9080;   // LD  r0,[0x80] -> 0x8001
    imem16[1] = 16'h6000;   // SHL r0,r0
    imem16[2] = 16'hF000;   // HALT

    // Reset state and 3-cycle timing: LDI r0,7F; LDI r1,01; ADD; BZ (not taken); BN (taken)
    clear_prog();
    imem8[0]    = 16'h807F;
    imem8[1]    = 16'h8401;
    imem8[2]    = 16'h1100;
    imem8[3]    = 16'hC050;
    imem8[4]    = 16'hD060;
    imem8[8'h60] = 16'hF000;
    do_reset();
    check("rst imem_req",  32'(imem_req8),  32'd1);
    check("rst imem_addr", 32'(imem_addr8), 32'd0);
    check("rst alu",       32'(alu8),       32'd0);
    check("rst stat",      32'(stat8),      32'd0);
    check("rst halted",    32'(halted8),    32'd0);
    edges(8);
    check("add not yet done", 32'(alu8),      32'd0);
    check("cycle8 no fetch",  32'(imem_req8), 32'd0);
    edges(1);
    check("cycle9 fetch",      32'(imem_req8),  32'd1);
    check("cycle9 fetch addr", 32'(imem_addr8), 32'd3);
    check("add 7F+01 result",  32'(alu8),       32'h80);
    check("add 7F+01 stat",    32'(stat8),      32'b0110);
    edges(3);
    check("bz not taken addr", 32'(imem_addr8), 32'd4);
    edges(3);
    check("bn taken addr",     32'(imem_addr8), 32'h60);
    check("branch keeps alu",  32'(alu8),       32'h80);

    // ALU vector table
    for (int i = 0; i < 11; i++) begin
      clear_prog();
      imem8[0] = {OP_LDI, 2'd0, 2'd0, vecs[i].a};
      imem8[1] = {OP_LDI, 2'd1, 2'd0, vecs[i].b};
      imem8[2] = {vecs[i].op, 2'd0, 2'd1, 8'h00};
      imem8[3] = {OP_ST, 2'd0, 2'd0, 8'h30};
      imem8[4] = 16'hF000;
      do_reset();
      wait_halt8($sformatf("vec%0d", i));
      if (vecs[i].chk_res) check($sformatf("vec%0d alu", i), 32'(alu8), 32'(vecs[i].exp_res));
      check($sformatf("vec%0d stat", i),    32'(stat8),   32'(vecs[i].exp_stat));
      check($sformatf("vec%0d r0", i),      32'(st_data), 32'(vecs[i].exp_mem));
      check($sformatf("vec%0d st addr", i), 32'(st_addr), 32'h30);
    end

    // SUB to zero then BZ taken
    clear_prog();
    imem8[0]     = 16'h8005;
    imem8[1]     = 16'h8405;
    imem8[2]     = 16'h2100;
    imem8[3]     = 16'hC020;
    imem8[8'h20] = 16'hF000;
    do_reset();
    edges(9);
    check("sub 5-5 alu",  32'(alu8),  32'd0);
    check("sub 5-5 stat", 32'(stat8), 32'b1001);
    edges(3);
    check("bz taken addr", 32'(imem_addr8), 32'h20);

    // ST with 3 wait cycles on the data port
    clear_prog();
    imem8[0] = 16'h885A;    // LDI r2,5A
    imem8[1] = 16'hA810;    // ST  r2,[0x10]
    imem8[2] = 16'hF000;
    dmem_wait = 3;
    do_reset();
    edges(4);
    check("st decode no dreq", 32'(dmem_req8), 32'd0);
    req_cnt = 0;
    bad     = 0;
    for (int k = 0; k < 4; k++) begin
      edges(1);
      if (dmem_req8) req_cnt++;
      if (dmem_addr8 !== 8'h10 || dmem_we8 !== 1'b1 || dmem_wdata8 !== 8'h5A) bad++;
    end
    check("st dreq cycles",   32'(req_cnt), 32'd4);
    check("st bus unstable",  32'(bad),     32'd0);
    edges(1);
    check("st dreq dropped",  32'(dmem_req8),  32'd0);
    check("st next fetch",    32'(imem_req8),  32'd1);
    check("st 6 cycle addr",  32'(imem_addr8), 32'd2);
    check("st data written",  32'(st_data),    32'h5A);

    // LD with one wait cycle, stored back to observe the register
    clear_prog();
    imem8[0] = 16'h9C44;    // LD r3,[0x44]
    imem8[1] = 16'hAC31;    // ST r3,[0x31]
    imem8[2] = 16'hF000;
    dmem_wait = 1;
    do_reset();
    wait_halt8("ld");
    check("ld data",    32'(st_data), 32'hE1);
    check("ld st addr", 32'(st_addr), 32'h31);
    check("ld keeps stat", 32'(stat8), 32'd0);

    // PC wrap from 0xFF to 0x00
    clear_prog();
    imem8[0] = 16'hB0FF;
    dmem_wait = 0;
    do_reset();
    edges(3);
    check("jmp to FF", 32'(imem_addr8), 32'hFF);
    edges(3);
    check("pc wrap",   32'(imem_addr8), 32'h00);

    // Reset in the middle of a stalled store
    clear_prog();
    imem8[0] = 16'h807F;
    imem8[1] = 16'h8401;
    imem8[2] = 16'h1100;
    imem8[3] = 16'hA010;
    imem8[4] = 16'hF000;
    dmem_wait = 50;
    do_reset();
    edges(13);
    check("pre-rst dreq", 32'(dmem_req8), 32'd1);
    check("pre-rst alu",  32'(alu8),      32'h80);
    #2;
    rst = 1'b1;
    #1;
    check("mid-rst dreq",      32'(dmem_req8),  32'd0);
    check("mid-rst ireq",      32'(imem_req8),  32'd0);
    check("mid-rst dwe",       32'(dmem_we8),   32'd0);
    check("mid-rst daddr",     32'(dmem_addr8), 32'd0);
    check("mid-rst dwdata",    32'(dmem_wdata8), 32'd0);
    check("mid-rst alu",       32'(alu8),       32'd0);
    check("mid-rst stat",      32'(stat8),      32'd0);
    check("mid-rst halted",    32'(halted8),    32'd0);
    check("mid-rst iaddr",     32'(imem_addr8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_wait = 0;
    #1;
    check("post-rst ireq",  32'(imem_req8),  32'd1);
    check("post-rst iaddr", 32'(imem_addr8), 32'd0);

    // 16-bit core: LD 0x8001, SHL, HALT
    do_reset();
    n = 0;
    while (!halted16 && n < 200) begin
      edges(1);
      n++;
    end
    check("w16 halted",  32'(halted16), 32'd1);
    check("w16 shl alu", 32'(alu16),    32'h0002);
    check("w16 shl stat", 32'(stat16),  32'b1000);
    req_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      if (imem_req16 || dmem_req16) req_cnt++;
    end
    check("w16 no req after halt", 32'(req_cnt),  32'd0);
    check("w16 stays halted",      32'(halted16), 32'd1);

    check("imem/dmem req overlap", 32'(overlap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_mcpu.md
PARAM_MCPU -- requirements
Module: param_mcpu

Interface
REQ-001 Parameter DATA_W, default 8: register/ALU/data-bus width, legal 8..32.
REQ-002 Parameter ADDR_W, default 8: PC and memory-address width, legal 4..8.
REQ-003 Parameter NREG, default 4: register-file depth, fixed at 4 (2-bit fields).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 imem_req  out  1 / imem_addr  out  ADDR_W: instruction fetch request and address (address = PC).
REQ-007 imem_ack  in  1 / imem_data  in  16: fetch complete and instruction word, valid when imem_ack=1.
REQ-008 dmem_req, dmem_we  out  1 each / dmem_addr  out  ADDR_W / dmem_wdata  out  DATA_W: data access.
REQ-009 dmem_ack  in  1 / dmem_rdata  in  DATA_W: data access complete and load data.
REQ-010 alu_result  out  DATA_W: registered result of the last ALU-class instruction.
REQ-011 stat  out  4: {C,V,N,Z}, registered.
REQ-012 halted  out  1: core is in HALT.

Function
REQ-013 Instruction format SHALL be op[15:12], rd[11:10], rs[9:8], imm[7:0]; imm is zero-extended to DATA_W, or truncated to ADDR_W when used as an address.
REQ-014 Opcodes SHALL be 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR, 8 LDI (rd=imm), 9 LD (rd=mem[imm]), A ST (mem[imm]=rd), B JMP, C BZ, D BN, E CMP (rd-rs, flags only), F HALT.
REQ-015 FSM states SHALL be FETCH, DECODE, EXEC, MEM, HALT.
REQ-016 FETCH: imem_req=1 until imem_ack; on ack, load IR, PC<=PC+1 modulo 2^ADDR_W, go to DECODE; ack in the same cycle as req is legal.
REQ-017 DECODE: read rd/rs into operand registers; go to MEM for LD/ST, HALT for HALT, otherwise EXEC.
REQ-018 EXEC: compute, write rd (ALU ops, LDI), load flags (ALU ops, CMP), load PC (JMP always; BZ if Z=1; BN if N=1), return to FETCH.
REQ-019 MEM: dmem_req=1 with addr/we/wdata held stable until dmem_ack; on ack, LD writes dmem_rdata to rd; return to FETCH.
REQ-020 Latency with zero-wait ack SHALL be 3 cycles per instruction; each wait cycle adds exactly one cycle.
REQ-021 ADD: C = carry out of bit DATA_W-1, V = signed overflow.
REQ-022 SUB/CMP: compute rd+~rs+1; C = carry out (1 = no borrow), V = signed overflow.
REQ-023 AND/OR/XOR: C=0, V=0.
REQ-024 SHL/SHR: shift by 1; C = bit shifted out, V=0.
REQ-025 All flag-setting ops: Z = (result==0), N = result[DATA_W-1].
REQ-026 NOP, LDI, LD, ST, JMP, BZ, BN SHALL leave stat and alu_result unchanged.
REQ-027 A branch's flag test SHALL use stat as it stands at the start of EXEC.
REQ-028 HALT is terminal: no requests are issued and halted=1 until reset.
REQ-029 imem_req and dmem_req SHALL never be asserted in the same cycle.
REQ-030 ack inputs received outside their matching request SHALL be ignored.

Reset
REQ-031 Asserting rst SHALL immediately force FETCH, PC=0, IR=0, all registers=0, stat=0, alu_result=0, halted=0, and deassert imem_req/dmem_req, including mid-transaction.
REQ-032 First fetch SHALL be of address 0, issued in the first cycle after rst deasserts.

Structure
REQ-033 Shared package pcpu_pkg SHALL hold the opcode constants, the FSM state enum and the flag bit indices.
REQ-034 The ALU SHALL be one combinational sub-module pcpu_alu (DATA_W-parametrised), returning result and the C, V, N, Z flags.

Verification
REQ-035 DATA_W=8, zero-wait: LDI r0,0x7F; LDI r1,0x01; ADD r0,r1 -> alu_result=0x80, stat C=0 V=1 N=1 Z=0, 9 cycles total.
REQ-036 SUB with r0=r1=0x05 -> result 0x00, Z=1, C=1; a following BZ 0x20 -> next imem_addr=0x20.
REQ-037 ST r2 to 0x10 with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with addr=0x10, we=1, data stable; instruction takes 6 cycles.
REQ-038 PC=0xFF fetch (ADDR_W=8) -> next fetch address 0x00.
REQ-039 rst pulsed while dmem_req=1 -> dmem_req drops in the same cycle, all outputs 0, next fetch from 0x00.
REQ-040 DATA_W=16: SHL on 0x8001 -> 0x0002, C=1; then HALT -> halted=1, no further imem_req.
